// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling 8N1 UART receiver feeding a show-ahead byte FIFO
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          uart_rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    input  logic                          err_clear
);

    localparam int DIV  = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW   = $clog2(OVERSAMPLE);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SC_MID    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        state, state_nxt;
    logic          sync1, rxs;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [SW-1:0] sc, sc_nxt;
    logic [2:0]    bc, bc_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          push, frame_set;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxs   <= sync1;
        end
    end

    // Tick phase restarts from zero on every start-bit detection.
    assign tick = (tcnt == TICK_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            tcnt <= '0;
        else if (state == S_IDLE || tick)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= S_IDLE;
            sc    <= '0;
            bc    <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            sc    <= sc_nxt;
            bc    <= bc_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sc_nxt    = sc;
        bc_nxt    = bc;
        shreg_nxt = shreg;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_nxt = S_START;
                    sc_nxt    = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sc == SC_MID) begin
                        if (rxs) begin
                            state_nxt = S_IDLE;
                        end else begin
                            sc_nxt    = '0;
                            bc_nxt    = '0;
                            state_nxt = S_DATA;
                        end
                    end else begin
                        sc_nxt = sc + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (sc == SC_LAST) begin
                        shreg_nxt = {rxs, shreg[7:1]};
                        sc_nxt    = '0;
                        bc_nxt    = bc + 3'd1;
                        if (bc == 3'd7)
                            state_nxt = S_STOP;
                    end else begin
                        sc_nxt = sc + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (sc == SC_LAST) begin
                        // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                        if (rxs) begin
                            push      = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            frame_set = 1'b1;
                            state_nxt = S_BREAK;
                        end
                    end else begin
                        sc_nxt = sc + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rxs)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]   cnt_nxt;
    logic [7:0]    head_nxt;
    logic          pop, push_ok;

    assign rx_valid = (fifo_count != '0);
    assign pop      = rx_valid && rx_ready;
    assign push_ok  = push && ((fifo_count < DEPTH_C) || pop);
    assign rd_nxt   = pop ? rd_ptr + 1'b1 : rd_ptr;
    // Next head bypasses the array when the incoming byte lands exactly at the new read slot.
    assign head_nxt = (push_ok && wr_ptr == rd_nxt) ? shreg : mem[rd_nxt];

    always_comb begin
        cnt_nxt = fifo_count;
        case ({push_ok, pop})
            2'b10:   cnt_nxt = fifo_count + 1'b1;
            2'b01:   cnt_nxt = fifo_count - 1'b1;
            default: cnt_nxt = fifo_count;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (push_ok)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rx_data     <= 8'h00;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_nxt;
            fifo_count <= cnt_nxt;
            if (cnt_nxt != '0)
                rx_data <= head_nxt;
            if (frame_set)
                frame_err <= 1'b1;
            else if (err_clear)
                frame_err <= 1'b0;
            if (push && !push_ok)
                overrun_err <= 1'b1;
            else if (err_clear)
                overrun_err <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Oversampling 8N1 UART receiver with a byte FIFO.
- Sits directly upstream of the Nios system: consumes the board UART_RXD pin and presents received bytes on a valid/ready stream, plus sticky error flags, for a PIO/Avalon-ST bridge.
- Decouples host bursts of inference input data from CPU polling latency.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- OVERSAMPLE, 16, sample ticks per bit
- FIFO_DEPTH, 16, bytes of buffering; power of two, at least 2

Ports:
- clk_clk  in  1  system clock (MAX10_CLK1_50)
- reset_reset_n  in  1  asynchronous, active-low reset
- uart_rxd  in  1  raw serial input, idle high, asynchronous to clk_clk
- rx_data  out  8  FIFO head byte
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer pops the head when rx_valid && rx_ready
- fifo_count  out  clog2(FIFO_DEPTH)+1  bytes held
- frame_err  out  1  sticky: stop bit sampled low
- overrun_err  out  1  sticky: byte dropped, FIFO full
- err_clear  in  1  one-cycle pulse clears both sticky flags

Behaviour:
- Interface: one clock, clk_clk; reset_reset_n is asynchronous and active-low. Reset values: rx_data=0x00, rx_valid=0, fifo_count=0, frame_err=0, overrun_err=0; synchroniser FFs=1; FSM=IDLE; all counters=0.
- Input path: uart_rxd passes through a 2-FF synchroniser; all decisions use the synchronised value (rxs).
- Tick generator:
  - DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)); 27 at defaults, giving a 432-clock bit.
  - Counter runs 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - Counter is held at 0 while in IDLE.
- FSM: IDLE, START, DATA, STOP, BREAK.
  - The sample counter sc counts ticks within a bit and the bit counter bc counts data bits.
  - IDLE: when rxs==0, go to START with sc=0.
  - START: on the tick where sc reaches 7 (mid-bit), sample rxs. If 1, treat as a glitch and return to IDLE. If 0, set sc=0, bc=0 and go to DATA.
  - DATA: on the tick where sc reaches 15, shift rxs into shreg (LSB first), set sc=0 and increment bc. After bit 7, go to STOP.
  - STOP: on the tick where sc reaches 15 (mid stop bit), sample rxs.
    - If 1: push shreg and go to IDLE. Returning at mid stop bit allows back-to-back frames.
    - If 0: set frame_err, discard the byte and go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. A held-low line therefore produces exactly one frame_err and no bytes.
- FIFO:
  - Circular buffer with wrapping pointers; show-ahead, so rx_data is the head entry.
  - rx_valid = (fifo_count != 0).
  - Pop when rx_valid && rx_ready.
  - A push is accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - If the FIFO is full and there is no pop, the byte is dropped and overrun_err is set.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - rx_data while empty: hold the last value; consumers must not rely on it.
- Latency: a pushed byte is visible on rx_valid/rx_data one clock after the push cycle. From the start-bit falling edge, this is about 9.5 bit times plus 3 clocks.
- Errors: err_clear clears both sticky flags. If a set event and err_clear occur in the same cycle, set wins.
- Reset mid-frame: everything returns to reset values immediately; the partial byte is lost. Reception resumes at the next falling edge after reset deasserts.
- rx_ready asserted while empty has no effect.

Test Plan:
- Drive 0xA5 at 432 clocks/bit with rx_ready=0 -> rx_valid=1, rx_data=0xA5, fifo_count=1 within 9.5 bit times plus 3 clocks; no error flags.
- Drive a 100-clock low pulse on an idle line -> no push; FSM back in IDLE; fifo_count=0.
- Send 0x3C with the stop bit low, then hold the line low for 5 bit times -> frame_err=1 exactly once, no push. Release and send 0x11 -> 0x11 received. Pulse err_clear -> frame_err=0.
- Send 17 bytes 0x00..0x10 with rx_ready=0 -> fifo_count=16, overrun_err=1, head=0x00. Drain with rx_ready=1 -> 0x00..0x0F in order, then rx_valid=0.
- With the FIFO full, hold rx_ready=1 so a pop coincides with the stop-bit push of 0x77 -> fifo_count stays 16, overrun_err stays 0, 0x77 is the last entry.
- Assert reset_reset_n low during data bit 4 -> all outputs at reset values immediately. After release, send 0x5A -> received correctly.
